// File: rtl/logic_arb_if.sv
// Handshake and shared-logic-unit bundle for logic_arb.
// The slave modport is the arbiter's view; the master modport is the requester/unit side.
interface logic_arb_if #(
  parameter int WIDTH = 32
);
  logic             i_req0_valid;
  logic [1:0]       i_req0_op;
  logic [WIDTH-1:0] i_req0_a;
  logic [WIDTH-1:0] i_req0_b;
  logic             o_req0_ready;
  logic             i_req1_valid;
  logic [1:0]       i_req1_op;
  logic [WIDTH-1:0] i_req1_a;
  logic [WIDTH-1:0] i_req1_b;
  logic             o_req1_ready;
  logic [1:0]       o_logcontrl;
  logic [WIDTH-1:0] o_A;
  logic [WIDTH-1:0] o_B;
  logic [WIDTH-1:0] i_logic;
  logic             o_rsp_valid;
  logic             o_rsp_id;
  logic [WIDTH-1:0] o_rsp_data;
  logic             i_rsp_ready;

  modport slave (
    input  i_req0_valid, i_req0_op, i_req0_a, i_req0_b,
    output o_req0_ready,
    input  i_req1_valid, i_req1_op, i_req1_a, i_req1_b,
    output o_req1_ready,
    output o_logcontrl, o_A, o_B,
    input  i_logic,
    output o_rsp_valid, o_rsp_id, o_rsp_data,
    input  i_rsp_ready
  );

  modport master (
    output i_req0_valid, i_req0_op, i_req0_a, i_req0_b,
    input  o_req0_ready,
    output i_req1_valid, i_req1_op, i_req1_a, i_req1_b,
    input  o_req1_ready,
    input  o_logcontrl, o_A, o_B,
    output i_logic,
    input  o_rsp_valid, o_rsp_id, o_rsp_data,
    output i_rsp_ready
  );
endinterface

// File: rtl/logic_arb.sv
// Two-requester round-robin sequencer for one shared AND/OR/NOR/XOR unit.
// One transaction in flight: IDLE accepts, BUSY samples the unit, RESP waits for the consumer.
module logic_arb #(
  parameter int WIDTH = 32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  logic_arb_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic             id_q, id_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic gnt_valid_s;
  logic gnt_id_s;
  logic accept_s;

  // Grant selection: rr_ptr's requester first, otherwise the other one.
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_id_s    = 1'b0;
    if (rr_ptr_q == 1'b0) begin
      if (bus.i_req0_valid) begin
        gnt_valid_s = 1'b1;
        gnt_id_s    = 1'b0;
      end else if (bus.i_req1_valid) begin
        gnt_valid_s = 1'b1;
        gnt_id_s    = 1'b1;
      end else begin
        gnt_valid_s = 1'b0;
      end
    end else begin
      if (bus.i_req1_valid) begin
        gnt_valid_s = 1'b1;
        gnt_id_s    = 1'b1;
      end else if (bus.i_req0_valid) begin
        gnt_valid_s = 1'b1;
        gnt_id_s    = 1'b0;
      end else begin
        gnt_valid_s = 1'b0;
      end
    end
  end

  // Readies are gated by reset so nothing looks accepted while held in reset.
  assign accept_s         = i_rst_n && (state_q == ST_IDLE) && gnt_valid_s;
  assign bus.o_req0_ready = accept_s && (gnt_id_s == 1'b0);
  assign bus.o_req1_ready = accept_s && (gnt_id_s == 1'b1);

  // Next-state and register updates for the IDLE/BUSY/RESP sequence.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_BUSY;
          id_d    = gnt_id_s;
          op_d    = gnt_id_s ? bus.i_req1_op : bus.i_req0_op;
          a_d     = gnt_id_s ? bus.i_req1_a  : bus.i_req0_a;
          b_d     = gnt_id_s ? bus.i_req1_b  : bus.i_req0_b;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        rsp_data_d  = bus.i_logic;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (bus.i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = ~id_q;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= 1'b0;
      id_q        <= 1'b0;
      op_q        <= 2'd0;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= {WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.o_logcontrl = op_q;
  assign bus.o_A         = a_q;
  assign bus.o_B         = b_q;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_id    = rsp_id_q;
  assign bus.o_rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_logic_arb.sv
// Bench for logic_arb: vector table, multi-cycle corner sequences and randomized traffic
// against a priority/result model; it also plays the external logic unit.
module tb_logic_arb;

  logic i_clk;
  logic i_rst_n;
  int   checks;
  int   errors;
  int   prio;

  logic_arb_if #(.WIDTH(32)) bus ();

  logic_arb #(.WIDTH(32)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return ~(a | b);
      default: return a ^ b;
    endcase
  endfunction

  assign bus.i_logic = ref_result(bus.o_logcontrl, bus.o_A, bus.o_B);

  typedef struct {
    logic        v0;
    logic [1:0]  op0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic        v1;
    logic [1:0]  op1;
    logic [31:0] a1;
    logic [31:0] b1;
    int          stall;
    logic        exp_id;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.i_req0_valid = 1'b0;
    bus.i_req1_valid = 1'b0;
    bus.i_rsp_ready  = 1'b0;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int          n;
    logic        gid;
    logic [1:0]  gop;
    logic [31:0] ga;
    logic [31:0] gb;
    @(negedge i_clk);
    bus.i_req0_valid = v.v0; bus.i_req0_op = v.op0; bus.i_req0_a = v.a0; bus.i_req0_b = v.b0;
    bus.i_req1_valid = v.v1; bus.i_req1_op = v.op1; bus.i_req1_a = v.a1; bus.i_req1_b = v.b1;
    bus.i_rsp_ready  = 1'b0;
    #1;
    n = 0;
    while (!(bus.o_req0_ready || bus.o_req1_ready) && n < 10) begin
      @(negedge i_clk);
      #1;
      n++;
    end
    chk({tag, " accept"}, {31'd0, bus.o_req0_ready | bus.o_req1_ready}, 32'd1);
    if (!(bus.o_req0_ready || bus.o_req1_ready)) begin
      clear_inputs();
      return;
    end
    chk({tag, " onehot"}, {31'd0, bus.o_req0_ready & bus.o_req1_ready}, 32'd0);
    gid = bus.o_req1_ready;
    chk({tag, " grant"}, {31'd0, gid}, {31'd0, v.exp_id});
    gop = gid ? v.op1 : v.op0;
    ga  = gid ? v.a1 : v.a0;
    gb  = gid ? v.b1 : v.b0;
    @(negedge i_clk);
    if (gid) bus.i_req1_valid = 1'b0;
    else     bus.i_req0_valid = 1'b0;
    #1;
    chk({tag, " busy_rdy"}, {30'd0, bus.o_req1_ready, bus.o_req0_ready}, 32'd0);
    chk({tag, " busy_rspv"}, {31'd0, bus.o_rsp_valid}, 32'd0);
    chk({tag, " busy_op"}, {30'd0, bus.o_logcontrl}, {30'd0, gop});
    chk({tag, " busy_A"}, bus.o_A, ga);
    chk({tag, " busy_B"}, bus.o_B, gb);
    @(negedge i_clk);
    #1;
    chk({tag, " rspv"}, {31'd0, bus.o_rsp_valid}, 32'd1);
    chk({tag, " rsp_id"}, {31'd0, bus.o_rsp_id}, {31'd0, v.exp_id});
    chk({tag, " rsp_data"}, bus.o_rsp_data, v.exp_data);
    for (int s = 0; s < v.stall; s++) begin
      @(negedge i_clk);
      #1;
      chk({tag, " stall_rspv"}, {31'd0, bus.o_rsp_valid}, 32'd1);
      chk({tag, " stall_data"}, bus.o_rsp_data, v.exp_data);
      chk({tag, " stall_id"}, {31'd0, bus.o_rsp_id}, {31'd0, v.exp_id});
      chk({tag, " stall_rdy"}, {30'd0, bus.o_req1_ready, bus.o_req0_ready}, 32'd0);
    end
    bus.i_rsp_ready = 1'b1;
    @(negedge i_clk);
    clear_inputs();
    #1;
    chk({tag, " rsp_done"}, {31'd0, bus.o_rsp_valid}, 32'd0);
    prio = v.exp_id ? 0 : 1;
  endtask

  initial begin
    vec_t rv;
    checks = 0;
    errors = 0;
    prio   = 0;
    bus.i_req0_op = 2'd0; bus.i_req0_a = 32'd0; bus.i_req0_b = 32'd0;
    bus.i_req1_op = 2'd0; bus.i_req1_a = 32'd0; bus.i_req1_b = 32'd0;
    clear_inputs();

    //            v0  op0   a0             b0             v1  op1   a1             b1             st  id    data
    vecs[0] = '{1'b1, 2'd1, 32'h0000_00F0, 32'h0000_000F, 1'b1, 2'd2, 32'd0,         32'd0,         0, 1'b0, 32'h0000_00FF};
    vecs[1] = '{1'b1, 2'd1, 32'h0000_00F0, 32'h0000_000F, 1'b1, 2'd2, 32'd0,         32'd0,         0, 1'b1, 32'hFFFF_FFFF};
    vecs[2] = '{1'b1, 2'd1, 32'h0000_00F0, 32'h0000_000F, 1'b1, 2'd2, 32'd0,         32'd0,         0, 1'b0, 32'h0000_00FF};
    vecs[3] = '{1'b1, 2'd1, 32'h0000_00F0, 32'h0000_000F, 1'b1, 2'd2, 32'd0,         32'd0,         0, 1'b1, 32'hFFFF_FFFF};
    vecs[4] = '{1'b1, 2'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, 2'd0, 32'd0,         32'd0,         0, 1'b0, 32'h00F0_1234};
    vecs[5] = '{1'b1, 2'd3, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 1'b0, 2'd0, 32'd0,         32'd0,         5, 1'b0, 32'h5555_5555};
    vecs[6] = '{1'b0, 2'd0, 32'd0,         32'd0,         1'b1, 2'd1, 32'h1234_0000, 32'h0000_5678, 0, 1'b1, 32'h1234_5678};
    vecs[7] = '{1'b1, 2'd3, 32'h0F0F_0F0F, 32'hFFFF_0000, 1'b1, 2'd0, 32'hFFFF_FFFF, 32'h1111_1111, 1, 1'b0, 32'hF0F0_0F0F};

    // Reset held with random inputs.
    i_rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      bus.i_req0_valid = 1'($urandom); bus.i_req0_op = 2'($urandom);
      bus.i_req0_a = $urandom; bus.i_req0_b = $urandom;
      bus.i_req1_valid = 1'($urandom); bus.i_req1_op = 2'($urandom);
      bus.i_req1_a = $urandom; bus.i_req1_b = $urandom;
      bus.i_rsp_ready = 1'($urandom);
      #1;
      chk("rst_rdy", {30'd0, bus.o_req1_ready, bus.o_req0_ready}, 32'd0);
      chk("rst_rsp", {29'd0, bus.o_rsp_valid, bus.o_rsp_id, |bus.o_rsp_data}, 32'd0);
      chk("rst_ops", {29'd0, |bus.o_logcontrl, |bus.o_A, |bus.o_B}, 32'd0);
    end
    @(negedge i_clk);
    clear_inputs();
    i_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      #1;
      chk("idle_rdy", {30'd0, bus.o_req1_ready, bus.o_req0_ready}, 32'd0);
      chk("idle_rspv", {31'd0, bus.o_rsp_valid}, 32'd0);
      chk("idle_A", bus.o_A, 32'd0);
    end

    for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset while BUSY: the dropped request never responds.
    @(negedge i_clk);
    bus.i_req0_valid = 1'b1; bus.i_req0_op = 2'd1;
    bus.i_req0_a = 32'h1357_9BDF; bus.i_req0_b = 32'h0000_0001;
    #1;
    chk("mid_accept", {31'd0, bus.o_req0_ready}, 32'd1);
    @(negedge i_clk);
    bus.i_req0_valid = 1'b0;
    #1;
    chk("mid_busy_A", bus.o_A, 32'h1357_9BDF);
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_A", bus.o_A, 32'd0);
    bus.i_rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge i_clk);
      #1;
      chk("mid_rst_rspv", {31'd0, bus.o_rsp_valid}, 32'd0);
    end
    i_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      #1;
      chk("mid_after_rspv", {31'd0, bus.o_rsp_valid}, 32'd0);
    end
    clear_inputs();
    prio = 0;
    run_txn(vecs[0], "post_rst");

    // Randomized traffic against the priority/result model.
    for (int t = 0; t < 40; t++) begin
      int pat;
      pat = $urandom_range(1, 3);
      rv.v0 = pat[0]; rv.v1 = pat[1];
      rv.op0 = 2'($urandom); rv.a0 = $urandom; rv.b0 = $urandom;
      rv.op1 = 2'($urandom); rv.a1 = $urandom; rv.b1 = $urandom;
      rv.stall = $urandom_range(0, 3);
      if (rv.v0 && rv.v1) rv.exp_id = (prio == 1);
      else                rv.exp_id = rv.v1;
      rv.exp_data = rv.exp_id ? ref_result(rv.op1, rv.a1, rv.b1) : ref_result(rv.op0, rv.a0, rv.b0);
      run_txn(rv, $sformatf("rnd%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
